// File: rtl/processinho_pkg.sv
// Shared definitions for the processinho register write-back path.
// The data width is fixed by the 4-bit general_register bank.
package processinho_pkg;

    localparam int DATA_W       = 4;
    localparam int DEF_NUM_REGS = 4;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_ADDR_W   = 4;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer holding pending register writes.
// The head entry is readable combinationally so it can be issued on the pop edge.
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Write-back queue: buffers register writes and retires one per cycle as a
// one-hot strobe plus shared data bus. Optional macro: WRITEBACK_BYPASS_EN.
module writeback_queue
    import processinho_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_data,
    input  logic                      issue_en,
    output logic [NUM_REGS-1:0]       set_value,
    output logic [DATA_W-1:0]         value_out,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      addr_error
);

    localparam int              ENTRY_W      = ADDR_W + DATA_W;
    localparam logic [ADDR_W:0] NUM_REGS_CMP = (ADDR_W + 1)'(NUM_REGS);

    logic                handshake;
    logic                bypass;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic                load;
    logic                in_range;
    logic [ENTRY_W-1:0]  head;
    logic [ADDR_W-1:0]   load_addr;
    logic [DATA_W-1:0]   load_data;
    logic [NUM_REGS-1:0] onehot;

    logic [NUM_REGS-1:0] set_value_q, set_value_d;
    logic [DATA_W-1:0]   value_out_q, value_out_d;
    logic                addr_error_q, addr_error_d;

    // Ready looks only at registered occupancy: a pop while full frees no slot this cycle.
    assign req_ready = !reset && !fifo_full;
    assign handshake = req_valid && req_ready;
    assign fifo_pop  = !fifo_empty && issue_en;

`ifdef WRITEBACK_BYPASS_EN
    assign bypass = handshake && fifo_empty && issue_en;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push = handshake && !bypass;
    assign load      = fifo_pop || bypass;
    assign load_addr = bypass ? req_addr : head[ENTRY_W-1:DATA_W];
    assign load_data = bypass ? req_data : head[DATA_W-1:0];
    assign in_range  = ({1'b0, load_addr} < NUM_REGS_CMP);

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({req_addr, req_data}),
        .rdata (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            assign onehot[gi] = (load_addr == IDX);
        end
    endgenerate

    // Out-of-range entries are still consumed, but only raise the sticky error.
    always_comb begin
        set_value_d  = '0;
        value_out_d  = value_out_q;
        addr_error_d = addr_error_q;
        if (load) begin
            value_out_d = load_data;
            if (in_range) begin
                set_value_d = onehot;
            end else begin
                addr_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            set_value_q  <= '0;
            value_out_q  <= '0;
            addr_error_q <= 1'b0;
        end else begin
            set_value_q  <= set_value_d;
            value_out_q  <= value_out_d;
            addr_error_q <= addr_error_d;
        end
    end

    assign set_value  = set_value_q;
    assign value_out  = value_out_q;
    assign addr_error = addr_error_q;

endmodule
